// File: rtl/hash_result_streamer.sv
`default_nettype none
// ============================================================================
// Module   : hash_result_streamer
// Purpose  : Queues finished 1344-bit digests (with mode and transaction ID)
//            and streams each one out as OUT_W-bit AXI-Stream beats, trimmed
//            to the digest length of its mode. Flags overflow and bad modes.
// Revision : 1.0 - initial release
// ============================================================================
module hash_result_streamer #(
    parameter int OUT_W = 64,
    parameter int DEPTH = 2,
    parameter int ID_W  = 32
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     in_valid,
    input  logic [3:0]               in_mode,
    input  logic [ID_W-1:0]          in_id,
    input  logic [1343:0]            in_data,
    output logic                     out_tvalid,
    input  logic                     out_tready,
    output logic [OUT_W-1:0]         out_tdata,
    output logic [OUT_W/8-1:0]       out_tkeep,
    output logic                     out_tlast,
    output logic [ID_W-1:0]          out_tid,
    output logic [3:0]               out_tmode,
    input  logic                     err_clr,
    output logic                     err_ovf,
    output logic                     err_mode,
    output logic [$clog2(DEPTH):0]   fill
);

    localparam int             c_aw       = $clog2(DEPTH);
    localparam int             c_kw       = OUT_W / 8;
    localparam logic [10:0]    c_out_w    = 11'(OUT_W);
    localparam logic [c_aw:0]  c_full     = (c_aw + 1)'(DEPTH);
    localparam logic [c_aw:0]  c_fill_one = (c_aw + 1)'(1);
    localparam logic [1343:0]  c_ones     = '1;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

    // Digest length in bits for a mode; illegal modes map to 0 (never loaded)
    function automatic logic [10:0] f_len(input logic [3:0] mode);
        if (!mode[3]) return mode[0] ? 11'd512 : 11'd256;
        case (mode[2:0])
            3'b000:  return 11'd1344;
            3'b001:  return 11'd1088;
            3'b010:  return 11'd256;
            3'b011:  return 11'd512;
            3'b100:  return 11'd224;
            3'b101:  return 11'd384;
            default: return 11'd0;
        endcase
    endfunction

    // Byte enables for a beat that still has 'bits' valid bits remaining
    function automatic logic [c_kw-1:0] f_keep(input logic [10:0] bits);
        logic [c_kw-1:0] ones;
        ones = '1;
        if (bits >= c_out_w) return ones;
        return ~(ones >> (bits >> 3));
    endfunction

    // Result buffer storage
    logic [1343:0]     r_mem_data [DEPTH];
    logic [3:0]        r_mem_mode [DEPTH];
    logic [ID_W-1:0]   r_mem_id   [DEPTH];
    logic [c_aw-1:0]   r_wr_ptr;
    logic [c_aw-1:0]   r_rd_ptr;
    logic [c_aw:0]     r_fill;

    // Output side state
    logic [0:0]        r_state;
    logic [1343:0]     r_shift;
    logic [10:0]       r_rem;
    logic              r_tvalid;
    logic [c_kw-1:0]   r_tkeep;
    logic              r_tlast;
    logic [ID_W-1:0]   r_tid;
    logic [3:0]        r_tmode;
    logic              r_err_ovf;
    logic              r_err_mode;

    logic              w_legal;
    logic              w_hs;
    logic              w_pop;
    logic              w_room;
    logic              w_push;
    logic              w_ovf_evt;
    logic              w_mode_evt;
    logic              w_ld_en;
    logic              w_ld_from_in;
    logic [c_aw-1:0]   w_ld_ptr;
    logic [1343:0]     w_ld_raw;
    logic [1343:0]     w_ld_data;
    logic [3:0]        w_ld_mode;
    logic [ID_W-1:0]   w_ld_id;
    logic [10:0]       w_ld_len;
    logic [10:0]       w_rem_nxt;

    assign w_legal    = ~(in_mode[3] & in_mode[2] & in_mode[1]);
    assign w_hs       = r_tvalid & out_tready;
    assign w_pop      = w_hs & r_tlast;
    // A final-beat pop frees a slot in the same cycle, so a full buffer still accepts
    assign w_room     = (r_fill != c_full) | w_pop;
    assign w_push     = in_valid & w_legal & w_room;
    assign w_ovf_evt  = in_valid & w_legal & ~w_room;
    assign w_mode_evt = in_valid & ~w_legal;
    assign w_rem_nxt  = r_rem - c_out_w;

    // Pick the next digest to present: queued head, or the incoming word when nothing else is queued
    always_comb begin
        w_ld_en      = 1'b0;
        w_ld_from_in = 1'b0;
        w_ld_ptr     = r_rd_ptr;
        if (r_state == ST_IDLE) begin
            if (r_fill != '0) begin
                w_ld_en = 1'b1;
            end else if (w_push) begin
                w_ld_en      = 1'b1;
                w_ld_from_in = 1'b1;
            end
        end else if (w_pop) begin
            if ((r_fill != '0) && (r_fill != c_fill_one)) begin
                w_ld_en  = 1'b1;
                w_ld_ptr = r_rd_ptr + 1'b1;
            end else if (w_push) begin
                w_ld_en      = 1'b1;
                w_ld_from_in = 1'b1;
            end
        end
    end

    assign w_ld_raw  = w_ld_from_in ? in_data : r_mem_data[w_ld_ptr];
    assign w_ld_mode = w_ld_from_in ? in_mode : r_mem_mode[w_ld_ptr];
    assign w_ld_id   = w_ld_from_in ? in_id   : r_mem_id[w_ld_ptr];
    assign w_ld_len  = f_len(w_ld_mode);
    // Zero every bit past the digest length so padding beats carry no stale state
    assign w_ld_data = w_ld_raw & ~(c_ones >> w_ld_len);

    // Buffer payload write; storage needs no reset since pointers guard validity
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= in_data;
            r_mem_mode[r_wr_ptr] <= in_mode;
            r_mem_id[r_wr_ptr]   <= in_id;
        end
    end

    // Pointers, occupancy and sticky error flags
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fill     <= '0;
            r_err_ovf  <= 1'b0;
            r_err_mode <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + 1'b1;
                2'b01:   r_fill <= r_fill - 1'b1;
                default: r_fill <= r_fill;
            endcase
            r_err_ovf  <= (r_err_ovf  & ~err_clr) | w_ovf_evt;
            r_err_mode <= (r_err_mode & ~err_clr) | w_mode_evt;
        end
    end

    // Output FSM: load a digest, shift out one beat per handshake, reload without a bubble
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= ST_IDLE;
            r_shift  <= '0;
            r_rem    <= '0;
            r_tvalid <= 1'b0;
            r_tkeep  <= '0;
            r_tlast  <= 1'b0;
            r_tid    <= '0;
            r_tmode  <= '0;
        end else if (w_ld_en) begin
            r_state  <= ST_STREAM;
            r_shift  <= w_ld_data;
            r_rem    <= w_ld_len;
            r_tvalid <= 1'b1;
            r_tkeep  <= f_keep(w_ld_len);
            r_tlast  <= (w_ld_len <= c_out_w);
            r_tid    <= w_ld_id;
            r_tmode  <= w_ld_mode;
        end else if (w_pop) begin
            r_state  <= ST_IDLE;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
        end else if (w_hs) begin
            r_shift  <= r_shift << OUT_W;
            r_rem    <= w_rem_nxt;
            r_tkeep  <= f_keep(w_rem_nxt);
            r_tlast  <= (w_rem_nxt <= c_out_w);
        end
    end

    assign out_tvalid = r_tvalid;
    assign out_tdata  = r_shift[1343 -: OUT_W];
    assign out_tkeep  = r_tkeep;
    assign out_tlast  = r_tlast;
    assign out_tid    = r_tid;
    assign out_tmode  = r_tmode;
    assign err_ovf    = r_err_ovf;
    assign err_mode   = r_err_mode;
    assign fill       = r_fill;

endmodule
`default_nettype wire

// File: tb/tb_hash_result_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_hash_result_streamer
// Purpose  : Scoreboard bench for hash_result_streamer (OUT_W=64, DEPTH=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hash_result_streamer;

    logic          clk = 1'b0;
    logic          rstn;
    logic          in_valid;
    logic [3:0]    in_mode;
    logic [31:0]   in_id;
    logic [1343:0] in_data;
    logic          out_tvalid;
    logic          out_tready;
    logic [63:0]   out_tdata;
    logic [7:0]    out_tkeep;
    logic          out_tlast;
    logic [31:0]   out_tid;
    logic [3:0]    out_tmode;
    logic          err_clr;
    logic          err_ovf;
    logic          err_mode;
    logic [1:0]    fill;

    hash_result_streamer #(.OUT_W(64), .DEPTH(2), .ID_W(32)) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_mode(in_mode), .in_id(in_id), .in_data(in_data),
        .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tdata(out_tdata),
        .out_tkeep(out_tkeep), .out_tlast(out_tlast), .out_tid(out_tid),
        .out_tmode(out_tmode), .err_clr(err_clr), .err_ovf(err_ovf),
        .err_mode(err_mode), .fill(fill)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic [31:0] id;
        logic [3:0]  mode;
    } beat_t;

    beat_t       sb_q[$];
    beat_t       exp_b;
    int          n_checks = 0;
    int          n_errors = 0;
    logic        stall_prev = 1'b0;
    logic [108:0] hold_snap;

    task automatic check_value(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int digest_bits(input logic [3:0] mode);
        if (!mode[3]) return mode[0] ? 512 : 256;
        case (mode[2:0])
            3'b000:  return 1344;
            3'b001:  return 1088;
            3'b010:  return 256;
            3'b011:  return 512;
            3'b100:  return 224;
            default: return 384;
        endcase
    endfunction

    function automatic logic [1343:0] make_digest(input int seed);
        logic [1343:0] d;
        d = '0;
        for (int b = 0; b < 168; b++) d[1343 - 8*b -: 8] = 8'(seed + b);
        return d;
    endfunction

    // Byte-by-byte reference: byte b of the digest lands in beat b/8, lane b%8 from the top
    task automatic push_expected(input logic [1343:0] d, input logic [3:0] mode, input logic [31:0] id);
        int    nbytes;
        int    nbeats;
        beat_t bt;
        nbytes = digest_bits(mode) / 8;
        nbeats = (nbytes + 7) / 8;
        for (int k = 0; k < nbeats; k++) begin
            bt = '0;
            for (int j = 0; j < 8; j++) begin
                if (k*8 + j < nbytes) begin
                    bt.data[63 - 8*j -: 8] = d[1343 - 8*(k*8 + j) -: 8];
                    bt.keep[7 - j] = 1'b1;
                end
            end
            bt.last = (k == nbeats - 1);
            bt.id   = id;
            bt.mode = mode;
            sb_q.push_back(bt);
        end
    endtask

    // Called at posedge+1; presents one digest for a single cycle
    task automatic send_digest(input logic [1343:0] d, input logic [3:0] mode,
                               input logic [31:0] id, input logic accept);
        in_valid = 1'b1;
        in_mode  = mode;
        in_id    = id;
        in_data  = d;
        if (accept) push_expected(d, mode, id);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int c = 0; c < 400; c++) begin
            if (sb_q.size() == 0) break;
            @(posedge clk); #1;
        end
        check_value(tag, sb_q.size(), 0);
    endtask

    // Beat monitor: scoreboard compare on handshake, hold check across stalls
    always @(negedge clk) begin
        if (rstn) begin
            if (stall_prev) begin
                check_value("hold_valid", out_tvalid, 1'b1);
                check_value("hold_beat", {out_tdata, out_tkeep, out_tlast, out_tid, out_tmode}, hold_snap);
            end
            if (out_tvalid && out_tready) begin
                if (sb_q.size() == 0) begin
                    check_value("unexpected_beat", {out_tid, out_tdata}, 0);
                end else begin
                    exp_b = sb_q.pop_front();
                    check_value("beat_data", out_tdata, exp_b.data);
                    check_value("beat_ctl", {out_tkeep, out_tlast, out_tid, out_tmode},
                                {exp_b.keep, exp_b.last, exp_b.id, exp_b.mode});
                end
            end
            stall_prev = out_tvalid && !out_tready;
            hold_snap  = {out_tdata, out_tkeep, out_tlast, out_tid, out_tmode};
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int guard;
        int bubbles;
        rstn = 1'b0; in_valid = 1'b0; in_mode = '0; in_id = '0; in_data = '0;
        out_tready = 1'b1; err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_value("rst_tvalid", out_tvalid, 0);
        check_value("rst_tlast", out_tlast, 0);
        check_value("rst_outs", {out_tdata, out_tkeep, out_tid, out_tmode}, 0);
        check_value("rst_flags", {err_ovf, err_mode, fill}, 0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // SHA-256: latency, first beat value, four full beats
        in_valid = 1'b1; in_mode = 4'b0000; in_id = 32'hA1; in_data = make_digest(0);
        push_expected(in_data, 4'b0000, 32'hA1);
        @(negedge clk);
        check_value("sha256_tvalid_t", out_tvalid, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_value("sha256_tvalid_t1", out_tvalid, 1);
        check_value("sha256_beat0", out_tdata, 64'h0001020304050607);
        check_value("sha256_fill", fill, 1);
        wait_drain("sha256_drain");

        // SHA3-224: short final beat
        send_digest(make_digest(8'hA0), 4'b1100, 32'hB2, 1'b1);
        wait_drain("sha224_drain");

        // SHAKE128 full width with ready toggling every cycle
        send_digest(make_digest(8'h40), 4'b1000, 32'hCAFE0001, 1'b1);
        for (int c = 0; c < 100; c++) begin
            if (sb_q.size() == 0) break;
            @(posedge clk); #1;
            out_tready = ~out_tready;
        end
        check_value("shake128_drain", sb_q.size(), 0);
        out_tready = 1'b1;
        @(posedge clk); #1;

        // Overflow: third digest dropped while stalled
        out_tready = 1'b0;
        send_digest(make_digest(1), 4'b0000, 32'd1, 1'b1);
        send_digest(make_digest(2), 4'b0000, 32'd2, 1'b1);
        send_digest(make_digest(3), 4'b0000, 32'd3, 1'b0);
        check_value("ovf_fill", fill, 2);
        check_value("ovf_flag", err_ovf, 1);
        out_tready = 1'b1;
        bubbles = 0;
        for (int c = 0; c < 100; c++) begin
            if (sb_q.size() == 0) break;
            if (!out_tvalid) bubbles++;
            @(posedge clk); #1;
        end
        check_value("ovf_drain", sb_q.size(), 0);
        check_value("ovf_no_bubble", bubbles, 0);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        check_value("ovf_clr", err_ovf, 0);

        // Illegal mode, then clear racing a new illegal mode
        send_digest(make_digest(9), 4'b1111, 32'h99, 1'b0);
        check_value("illegal_flag", err_mode, 1);
        check_value("illegal_fill", fill, 0);
        check_value("illegal_tvalid", out_tvalid, 0);
        err_clr = 1'b1;
        send_digest(make_digest(9), 4'b1110, 32'h9A, 1'b0);
        err_clr = 1'b0;
        check_value("clr_vs_err", err_mode, 1);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        check_value("mode_clr", err_mode, 0);

        // Write coincident with final-beat pop on a full buffer
        out_tready = 1'b0;
        send_digest(make_digest(16), 4'b0000, 32'h10, 1'b1);
        send_digest(make_digest(17), 4'b0000, 32'h11, 1'b1);
        check_value("sim_fill_pre", fill, 2);
        out_tready = 1'b1;
        guard = 0;
        while (!(out_tvalid && out_tlast && out_tid == 32'h10) && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check_value("sim_align", guard < 20, 1);
        send_digest(make_digest(18), 4'b1011, 32'h12, 1'b1);
        check_value("sim_fill_post", fill, 2);
        check_value("sim_no_ovf", err_ovf, 0);
        wait_drain("sim_drain");

        // Asynchronous reset during beat 2
        send_digest(make_digest(5), 4'b0001, 32'h55, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rstn = 1'b0;
        #1;
        check_value("mid_rst_tvalid", out_tvalid, 0);
        check_value("mid_rst_outs", {out_tdata, out_tkeep, out_tlast, out_tid, out_tmode}, 0);
        check_value("mid_rst_flags", {err_ovf, err_mode, fill}, 0);
        sb_q.delete();
        repeat (2) @(posedge clk);
        #3 rstn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check_value("post_rst_idle", {out_tvalid, fill}, 0);
        end
        send_digest(make_digest(7), 4'b0000, 32'h77, 1'b1);
        wait_drain("post_rst_drain");

        repeat (3) @(posedge clk);
        check_value("sb_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hash_result_streamer.md
Name: hash_result_streamer

Overview:
- Collects finished digests from the combined SHA2/SHAKE hash top.
- Each digest arrives as a 1344-bit, MSB-aligned word with a valid pulse. The block queues it with its mode and transaction ID in a DEPTH-entry result buffer.
- Each queued digest is then streamed out as an AXI-Stream-style sequence of OUT_W-bit beats. The number of beats depends on the digest length of that job's mode.
- Replaces the raw 1344-bit dout/dout_valid path towards the system bus, adds backpressure tolerance, and reports overflow and illegal modes.

Parameters:
- OUT_W, 64, output beat width in bits; multiple of 8, range 8..1344.
- DEPTH, 2, result buffer entries; power of 2, at least 2.
- ID_W, 32, transaction ID width.

Ports:
- clk  input  1  system clock
- rstn  input  1  asynchronous active-low reset
- in_valid  input  1  single-cycle digest-valid pulse from the hash top
- in_mode  input  4  algo_mode of the job; same encoding as the hash top
- in_id  input  ID_W  transaction ID captured with the digest
- in_data  input  1344  digest; first digest byte in in_data[1343:1336]
- out_tvalid  output  1  output beat valid
- out_tready  input  1  downstream ready
- out_tdata  output  OUT_W  beat data; first byte in [OUT_W-1 -: 8]
- out_tkeep  output  OUT_W/8  byte enables; bit i covers tdata[8i+7:8i]
- out_tlast  output  1  last beat of the digest
- out_tid  output  ID_W  ID of the current digest
- out_tmode  output  4  mode of the current digest
- err_clr  input  1  clears both sticky error flags
- err_ovf  output  1  sticky: a digest was dropped because the buffer was full
- err_mode  output  1  sticky: a digest was dropped because its mode was illegal
- fill  output  clog2(DEPTH)+1  number of occupied entries

Behaviour:
- Reset (rstn low, asynchronous) forces:
  - out_tvalid, out_tlast, err_ovf, err_mode and fill to 0;
  - out_tdata, out_tkeep, out_tid and out_tmode to 0;
  - read and write pointers to 0, and the FSM to IDLE.
- Reset mid-stream abandons the digest in flight and all queued entries.
- Digest length L in bits, by mode:
  - SHA2 (in_mode[3]=0): bit0=0 gives 256 (SHA-256); bit0=1 gives 512 (SHA-512). Bits 2:1 are ignored.
  - SHAKE: 000=1344, 001=1088, 010=256, 011=512, 100=224, 101=384.
  - Modes 1110 and 1111 are illegal.
- Write side, on in_valid:
  - Illegal mode: entry dropped, err_mode set.
  - Otherwise, if fill==DEPTH and no final-beat pop happens this cycle: entry dropped, err_ovf set.
  - Otherwise {data, mode, id} is written at the write pointer, which increments and wraps modulo DEPTH.
  - A write and a final-beat pop in the same cycle are both honoured, even when the buffer is full; fill is unchanged.
- err_clr clears both flags. If err_clr and a new error occur in the same cycle, the flag ends up set.
- Beat count N = ceil(L/OUT_W). The last beat carries R = L - (N-1)*OUT_W valid bits.
- Output FSM:
  - IDLE: if fill>0, load the head entry into registers and go to STREAM with beat counter k=0.
  - STREAM: present beat k with out_tvalid=1.
    - Beat k data is in_data[1343-k*OUT_W -: OUT_W]. Bits beyond L are forced to 0.
    - out_tkeep is all ones, except on the last beat, where only the top R/8 bits are set.
    - out_tlast=1 when k==N-1.
  - On a handshake (out_tvalid & out_tready): k increments. On the last beat, the entry is popped and the read pointer advances.
    - If another entry is queued, it is loaded in the same cycle and the next beat is presented in the following cycle, with no bubble.
    - Otherwise the FSM returns to IDLE.
- Output hold: while out_tvalid=1 and out_tready=0, tdata, tkeep, tlast, tid and tmode stay stable. out_tvalid never drops without a handshake.
- Latency: an in_valid at cycle t into an empty buffer gives out_tvalid=1 at t+1.
- fill is updated in the cycle after the write or pop event.
- Throughput: one beat per cycle when out_tready is held high.

Test Plan:
- SHA-256 with OUT_W=64: in_mode=4'b0000, in_data[1343:1088]=0x00..1F (bytes), tready=1.
  - Expect 4 beats: 0x0001020304050607 … 0x18191A1B1C1D1E1F, tkeep=0xFF on all beats, tlast on beat 3, out_tvalid rising at t+1.
- SHA3-224: in_mode=4'b1100.
  - Expect 4 beats; beat 3 has tkeep=0xF0, tdata[31:0]=0, tlast=1.
- SHAKE128 with tready toggling 1,0,1,0:
  - Expect 21 beats, tlast on beat 20.
  - Data stays stable during stalls; tid and tmode equal the captured values on every beat.
- Overflow with DEPTH=2, tready=0: send 3 valid digests with IDs 1, 2, 3.
  - Expect fill=2 and err_ovf=1.
  - After releasing tready, expect IDs 1 then 2 back-to-back with no bubble. ID 3 never appears.
  - err_clr returns err_ovf to 0.
- Illegal mode and simultaneous events:
  - in_mode=4'b1111: dropped, err_mode=1, fill unchanged.
  - With fill=2, an in_valid coincident with a final-beat handshake is accepted and fill stays 2.
- Reset mid-stream: assert rstn=0 during beat 2.
  - Expect all outputs 0 immediately (asynchronously).
  - After release, expect out_tvalid=0 until a new in_valid arrives.
